tmip_out_rx: RTL and testbench

TMIP_OUT_RX -- requirements
Module: tmip_out_rx

---
 rtl/tmip_out_rx_pkg.sv | 20 ++
 rtl/tmip_rx_fifo.sv | 89 ++++++++
 rtl/tmip_out_rx.sv | 199 +++++++++++++++++++
 tb/tb_tmip_out_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmip_out_rx_pkg.sv
// Shared types and widths for the TMIP result-stream receiver.
package tmip_out_rx_pkg;

   localparam int TMIP_WORD_W = 20;   // default result word width
   localparam int TMIP_CNT_W  = 9;    // exp_cnt width (1..256)
   localparam int TMIP_IDX_W  = 8;    // res_idx width (modulo 256)

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RX    = 2'd2,
      ST_DONE  = 2'd3
   } rx_state_e;

   // Receiver is considered busy while waiting for or receiving a stream
   function automatic logic is_busy(input rx_state_e st);
      return (st == ST_ARMED) || (st == ST_RX);
   endfunction

endpackage

// File: rtl/tmip_rx_fifo.sv
// Synchronous word buffer with registered pointers and full/empty flags.
// A push into a full buffer is taken only when the same cycle pops the head.
module tmip_rx_fifo #(
   parameter int DW    = 29,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          wr_en_s, rd_en_s;

   // Qualify pop with data present and push with space (or a same-cycle pop)
   always_comb begin
      rd_en_s = pop & ~empty_q;
      wr_en_s = push & (~full_q | rd_en_s);
   end

   // Next storage, pointers, occupancy and flags
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_DEPTH);
      empty_d = (count_d == CNT_ZERO);
   end

   // Register storage and control state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= CNT_ZERO;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign full      = full_q;
   assign empty     = empty_q;

endmodule

// File: rtl/tmip_out_rx.sv
// Deserialises the TMIP transmitter's MSB-first bit stream into result words,
// tags each word with its index and last flag, and buffers them for a
// valid/ready consumer. Protocol violations are reported as sticky flags.
module tmip_out_rx
   import tmip_out_rx_pkg::*;
#(
   parameter int WORD_W     = TMIP_WORD_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [TMIP_CNT_W-1:0] exp_cnt,
   input  logic                  out_valid,
   input  logic                  out_value,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WORD_W-1:0]     res_data,
   output logic [TMIP_IDX_W-1:0] res_idx,
   output logic                  res_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err_gap,
   output logic                  err_ovf,
   output logic                  err_unexp
);

   localparam int BW      = $clog2(WORD_W);
   localparam int ENTRY_W = 1 + TMIP_IDX_W + WORD_W;
   localparam logic [BW-1:0]         BIT_LAST = BW'(WORD_W - 1);
   localparam logic [BW-1:0]         BIT_ONE  = BW'(1);
   localparam logic [BW-1:0]         BIT_ZERO = BW'(0);
   localparam logic [TMIP_CNT_W-1:0] CNT_ONE  = 9'd1;

   rx_state_e               state_q, state_d;
   logic [TMIP_CNT_W-1:0]   exp_q, exp_d;
   logic [TMIP_CNT_W-1:0]   wcnt_q, wcnt_d;
   logic [BW-1:0]           bcnt_q, bcnt_d;
   logic [WORD_W-1:0]       shift_q, shift_d;
   logic                    pend_q, pend_d;
   logic [WORD_W-1:0]       pend_data_q, pend_data_d;
   logic [TMIP_IDX_W-1:0]   pend_idx_q, pend_idx_d;
   logic                    pend_last_q, pend_last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_gap_q, err_gap_d;
   logic                    err_ovf_q, err_ovf_d;
   logic                    err_unexp_q, err_unexp_d;

   logic [WORD_W-1:0]  word_s;
   logic               last_word_s;
   logic               pop_s, push_s, drop_s;
   logic               fifo_full_s, fifo_empty_s;
   logic [ENTRY_W-1:0] fifo_head_s;

   // Word assembly view and buffer handshake; a completed word waits one
   // cycle in the pending register so the next word can start shifting.
   always_comb begin
      word_s      = {shift_q[WORD_W-2:0], out_value};
      last_word_s = (wcnt_q == (exp_q - CNT_ONE));
      pop_s       = ~fifo_empty_s & res_ready;
      drop_s      = pend_q & fifo_full_s & ~pop_s;
      push_s      = pend_q & ~drop_s;
   end

   // Stream state machine: arming, bit shifting, word completion, errors
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      wcnt_d      = wcnt_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      pend_d      = 1'b0;
      pend_data_d = pend_data_q;
      pend_idx_d  = pend_idx_q;
      pend_last_d = pend_last_q;
      done_d      = 1'b0;
      err_gap_d   = err_gap_q;
      err_ovf_d   = err_ovf_q | drop_s;
      err_unexp_d = err_unexp_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ARMED;
               exp_d       = exp_cnt;
               wcnt_d      = {TMIP_CNT_W{1'b0}};
               bcnt_d      = BIT_ZERO;
               shift_d     = {WORD_W{1'b0}};
               err_gap_d   = 1'b0;
               err_ovf_d   = 1'b0;
               err_unexp_d = out_valid;
            end else begin
               err_unexp_d = err_unexp_q | out_valid;
            end
         end
         ST_ARMED, ST_RX: begin
            if (out_valid) begin
               state_d = ST_RX;
               shift_d = word_s;
               if (bcnt_q == BIT_LAST) begin
                  bcnt_d      = BIT_ZERO;
                  wcnt_d      = wcnt_q + CNT_ONE;
                  pend_d      = 1'b1;
                  pend_data_d = word_s;
                  pend_idx_d  = wcnt_q[TMIP_IDX_W-1:0];
                  pend_last_d = last_word_s;
                  if (last_word_s) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RX;
                  end
               end else begin
                  bcnt_d = bcnt_q + BIT_ONE;
               end
            end else if (bcnt_q != BIT_ZERO) begin
               // Valid dropped mid-word: abandon the partial word
               err_gap_d = 1'b1;
               bcnt_d    = BIT_ZERO;
               shift_d   = {WORD_W{1'b0}};
            end else begin
               bcnt_d = BIT_ZERO;
            end
         end
         ST_DONE: begin
            err_unexp_d = err_unexp_q | out_valid;
            if (fifo_empty_s && !pend_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = is_busy(state_d);
   end

   // Register receiver state and status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         exp_q       <= {TMIP_CNT_W{1'b0}};
         wcnt_q      <= {TMIP_CNT_W{1'b0}};
         bcnt_q      <= BIT_ZERO;
         shift_q     <= {WORD_W{1'b0}};
         pend_q      <= 1'b0;
         pend_data_q <= {WORD_W{1'b0}};
         pend_idx_q  <= {TMIP_IDX_W{1'b0}};
         pend_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_gap_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unexp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         wcnt_q      <= wcnt_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         pend_idx_q  <= pend_idx_d;
         pend_last_q <= pend_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_gap_q   <= err_gap_d;
         err_ovf_q   <= err_ovf_d;
         err_unexp_q <= err_unexp_d;
      end
   end

   tmip_rx_fifo #(
      .DW    (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data ({pend_last_q, pend_idx_q, pend_data_q}),
      .pop       (pop_s),
      .head_data (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign res_valid = ~fifo_empty_s;
   assign res_last  = fifo_head_s[ENTRY_W-1];
   assign res_idx   = fifo_head_s[WORD_W +: TMIP_IDX_W];
   assign res_data  = fifo_head_s[WORD_W-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_gap   = err_gap_q;
   assign err_ovf   = err_ovf_q;
   assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_tmip_out_rx.sv
// Self-checking bench for tmip_out_rx: table of single-word streams plus
// hand-written multi-word sequences, all checked through a scoreboard queue.
module tb_tmip_out_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [8:0]  exp_cnt;
   logic        out_valid;
   logic        out_value;
   logic        res_valid;
   logic        res_ready;
   logic [19:0] res_data;
   logic [7:0]  res_idx;
   logic        res_last;
   logic        busy;
   logic        done;
   logic        err_gap;
   logic        err_ovf;
   logic        err_unexp;

   typedef struct packed {
      logic [19:0] data;
      logic [7:0]  idx;
      logic        last;
   } exp_t;

   typedef struct {
      logic [19:0] din;
      logic [19:0] edata;
      logic [7:0]  eidx;
      logic        elast;
   } vec_t;

   exp_t  exp_q[$];
   vec_t  tbl[5];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    done_seen = 0;
   logic  rand_ready = 1'b0;
   logic [19:0] words[8];

   tmip_out_rx #(.WORD_W(20), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .exp_cnt   (exp_cnt),
      .out_valid (out_valid),
      .out_value (out_value),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_idx   (res_idx),
      .res_last  (res_last),
      .busy      (busy),
      .done      (done),
      .err_gap   (err_gap),
      .err_ovf   (err_ovf),
      .err_unexp (err_unexp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // One clock: sample outputs at negedge (scoreboard pops), then pass posedge
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (done) done_seen++;
      if (res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", res_idx, res_data);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", 32'(res_data), 32'(e.data));
            chk("word_idx",  32'(res_idx),  32'(e.idx));
            chk("word_last", 32'(res_last), 32'(e.last));
         end
      end
      @(posedge clk);
      #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_bits(input logic [19:0] w, input int nbits);
      for (int b = 19; b > 19 - nbits; b--) begin
         out_valid = 1'b1;
         out_value = w[b];
         step();
      end
   endtask

   task automatic send_word(input logic [19:0] w);
      send_bits(w, 20);
   endtask

   task automatic drain(input int max_cyc, input string name);
      int c = 0;
      while (exp_q.size() != 0 && c < max_cyc) begin
         step();
         c++;
      end
      chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic settle();
      for (int k = 0; k < 3; k++) step();
   endtask

   task automatic arm(input logic [8:0] n);
      start   = 1'b1;
      exp_cnt = n;
      step();
      start   = 1'b0;
      done_seen = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"},  32'(res_data),  32'd0);
      chk({tag, "_res_idx"},   32'(res_idx),   32'd0);
      chk({tag, "_res_last"},  32'(res_last),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_err_gap"},   32'(err_gap),   32'd0);
      chk({tag, "_err_ovf"},   32'(err_ovf),   32'd0);
      chk({tag, "_err_unexp"}, 32'(err_unexp), 32'd0);
   endtask

   initial begin
      logic [19:0] w;
      rst_n = 1'b0; start = 1'b0; exp_cnt = 9'd0;
      out_valid = 1'b0; out_value = 1'b0; res_ready = 1'b0;

      tbl[0] = '{20'hA5A5A, 20'hA5A5A, 8'd0, 1'b1};
      tbl[1] = '{20'h00000, 20'h00000, 8'd0, 1'b1};
      tbl[2] = '{20'hFFFFF, 20'hFFFFF, 8'd0, 1'b1};
      tbl[3] = '{20'h80001, 20'h80001, 8'd0, 1'b1};
      tbl[4] = '{20'h5A5A5, 20'h5A5A5, 8'd0, 1'b1};

      // Reset state
      step(); step(); step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Single-word streams: latency, done pulse, head contents
      for (int i = 0; i < 5; i++) begin
         res_ready = 1'b0;
         arm(9'd1);
         chk("t1_busy", 32'(busy), 32'd1);
         exp_q.push_back('{data: tbl[i].edata, idx: tbl[i].eidx, last: tbl[i].elast});
         send_word(tbl[i].din);
         out_valid = 1'b0;
         chk("t1_done_pulse", 32'(done), 32'd1);
         chk("t1_valid_n1", 32'(res_valid), 32'd0);
         step();
         chk("t1_valid_n2", 32'(res_valid), 32'd1);
         chk("t1_done_clr", 32'(done), 32'd0);
         chk("t1_head_data", 32'(res_data), 32'(tbl[i].edata));
         chk("t1_head_last", 32'(res_last), 32'(tbl[i].elast));
         res_ready = 1'b1;
         drain(10, "t1");
         settle();
         chk("t1_busy_end", 32'(busy), 32'd0);
         chk("t1_valid_end", 32'(res_valid), 32'd0);
      end

      // Sixteen back-to-back words, ready always high; a start mid-stream is ignored
      res_ready = 1'b1;
      arm(9'd16);
      for (int i = 0; i < 16; i++) begin
         w = 20'(i * 20'h1111 + 20'h00ABC);
         exp_q.push_back('{data: w, idx: 8'(i), last: (i == 15)});
         if (i == 5) begin
            start = 1'b1;
            exp_cnt = 9'd2;
         end else begin
            start = 1'b0;
         end
         send_word(w);
      end
      start = 1'b0;
      out_valid = 1'b0;
      drain(12, "t2");
      settle();
      chk("t2_done_count", 32'(done_seen), 32'd1);
      chk("t2_err_gap", 32'(err_gap), 32'd0);
      chk("t2_err_ovf", 32'(err_ovf), 32'd0);
      chk("t2_err_unexp", 32'(err_unexp), 32'd0);

      // Overflow: ready low, only first four words survive
      res_ready = 1'b0;
      arm(9'd8);
      for (int i = 0; i < 8; i++) begin
         words[i] = 20'(32'h3C000 + i * 32'h00111);
         if (i < 4) exp_q.push_back('{data: words[i], idx: 8'(i), last: 1'b0});
         send_word(words[i]);
      end
      out_valid = 1'b0;
      step(); step();
      chk("t3_err_ovf", 32'(err_ovf), 32'd1);
      chk("t3_valid", 32'(res_valid), 32'd1);
      chk("t3_head_idx", 32'(res_idx), 32'd0);
      step(); step(); step();
      chk("t3_hold_data", 32'(res_data), 32'(words[0]));
      chk("t3_hold_idx", 32'(res_idx), 32'd0);
      chk("t3_done_count", 32'(done_seen), 32'd1);
      res_ready = 1'b1;
      drain(10, "t3");
      settle();
      chk("t3_valid_end", 32'(res_valid), 32'd0);

      // Gap mid-word: partial word discarded, index 2 reused
      res_ready = 1'b1;
      arm(9'd4);
      chk("t4_gap_clear", 32'(err_gap), 32'd0);
      exp_q.push_back('{data: 20'h12345, idx: 8'd0, last: 1'b0});
      exp_q.push_back('{data: 20'h6789A, idx: 8'd1, last: 1'b0});
      send_word(20'h12345);
      send_word(20'h6789A);
      send_bits(20'hFFFFF, 7);
      out_valid = 1'b0;
      step();
      chk("t4_err_gap", 32'(err_gap), 32'd1);
      exp_q.push_back('{data: 20'hBCDEF, idx: 8'd2, last: 1'b0});
      exp_q.push_back('{data: 20'h0F0F0, idx: 8'd3, last: 1'b1});
      send_word(20'hBCDEF);
      send_word(20'h0F0F0);
      out_valid = 1'b0;
      drain(10, "t4");
      settle();
      chk("t4_gap_sticky", 32'(err_gap), 32'd1);
      chk("t4_err_ovf", 32'(err_ovf), 32'd0);

      // Unexpected valid in IDLE, then reset in the middle of a stream
      out_valid = 1'b1;
      out_value = 1'b1;
      step();
      out_valid = 1'b0;
      chk("t5_err_unexp", 32'(err_unexp), 32'd1);
      step();
      chk("t5_no_valid", 32'(res_valid), 32'd0);
      res_ready = 1'b0;
      arm(9'd4);
      chk("t5_unexp_clr", 32'(err_unexp), 32'd0);
      send_word(20'h11111);
      send_word(20'h22222);
      send_bits(20'h33333, 10);
      rst_n = 1'b0;
      out_valid = 1'b0;
      step();
      chk_all_zero("t5_rst");
      rst_n = 1'b1;
      done_seen = 0;
      settle();
      chk("t5_no_done", 32'(done_seen), 32'd0);
      chk("t5_valid_after", 32'(res_valid), 32'd0);

      // Full 256-word stream with random ready and random inter-word gaps
      rand_ready = 1'b1;
      arm(9'd256);
      for (int i = 0; i < 256; i++) begin
         w = 20'($urandom);
         exp_q.push_back('{data: w, idx: 8'(i), last: (i == 255)});
         send_word(w);
         if ($urandom_range(0, 3) == 0) begin
            out_valid = 1'b0;
            step();
         end
      end
      out_valid = 1'b0;
      rand_ready = 1'b0;
      res_ready = 1'b1;
      drain(100, "t6");
      settle();
      chk("t6_done_count", 32'(done_seen), 32'd1);
      chk("t6_err_ovf", 32'(err_ovf), 32'd0);
      chk("t6_err_gap", 32'(err_gap), 32'd0);
      chk("t6_busy_end", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
